stopwatch_ctrl: RTL and testbench

- Control sequencer for the stopwatch datapath (counting unit plus seven-segment display).
- Replaces derived-clock muxing and level-sensitive button handling with a single-clock design:
  - synchronises and debounces the pause/clear buttons and adjust/select switches;
  - runs a run/pause/adjust state machine;
  - issues single-cycle count enables (1 Hz normal, 2 Hz adjust) and a clear pulse to the counter.
- Also provides a blink gate for the display in adjust mode.

---
 rtl/stopwatch_ctrl.sv | 176 +++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer on a single clock.
// Synchronises the raw inputs, debounces the buttons and runs the
// STOPPED/RUNNING/PAUSED/ADJUST state machine. It issues one-cycle count
// enables and clear pulses to the counter, and a blink gate for the display.
// Ports:
//   clk, reset_n            - system clock, asynchronous active-low reset
//   btn_pause, btn_clear    - raw active-high buttons (debounced internally)
//   sw_adj, sw_sel          - raw switches (synchronised only)
//   count_tick, count_clear - one-cycle enables to the counter
//   running, adjust, state  - registered state indications
//   select                  - synchronised sw_sel (0 = minutes, 1 = seconds)
//   blink_on                - display gate, 1 = digits visible
module stopwatch_ctrl #(
  parameter int unsigned TICK_1HZ_DIV = 100000000,
  parameter int unsigned TICK_2HZ_DIV = 50000000,
  parameter int unsigned DB_CYCLES    = 65535,
  parameter int unsigned BLINK_DIV    = 25000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_pause,
  input  logic       btn_clear,
  input  logic       sw_adj,
  input  logic       sw_sel,
  output logic       count_tick,
  output logic       count_clear,
  output logic       running,
  output logic       adjust,
  output logic       select,
  output logic       blink_on,
  output logic [1:0] state
);

  localparam int unsigned PW = (TICK_1HZ_DIV > 1) ? $clog2(TICK_1HZ_DIV) : 1;
  localparam int unsigned DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  // Bit positions in the synchroniser vector
  localparam int unsigned I_PAUSE = 0;
  localparam int unsigned I_CLEAR = 1;
  localparam int unsigned I_ADJ   = 2;
  localparam int unsigned I_SEL   = 3;

  typedef enum logic [1:0] {
    ST_STOPPED = 2'b00,
    ST_RUNNING = 2'b01,
    ST_PAUSED  = 2'b10,
    ST_ADJUST  = 2'b11
  } state_t;

  logic [3:0]          r_sync1;
  logic [3:0]          r_sync2;
  logic [1:0][DW-1:0]  r_db_cnt;
  logic [1:0]          r_db_lvl;
  logic [1:0]          r_press;
  state_t              r_state;
  logic [PW-1:0]       r_presc;
  logic [BW-1:0]       r_blink_cnt;

  state_t              w_state_nxt;
  logic                w_clr_press;
  logic                w_pause_press;
  logic                w_adj;
  logic                w_adj_edge;
  logic                w_presc_zero;
  logic                w_presc_run;
  logic [PW-1:0]       w_presc_limit;

  // Two-flop synchroniser for every raw input
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {sw_sel, sw_adj, btn_clear, btn_pause};
      r_sync2 <= r_sync1;
    end
  end

  // Button debounce: level flips after DB_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_db_cnt <= '0;
      r_db_lvl <= '0;
      r_press  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        r_press[i] <= 1'b0;
        if (r_sync2[i] == r_db_lvl[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DW'(DB_CYCLES - 1)) begin
          r_db_cnt[i] <= '0;
          r_db_lvl[i] <= r_sync2[i];
          r_press[i]  <= r_sync2[i];  // rising edge only; release is silent
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DW'(1);
        end
      end
    end
  end

  assign w_pause_press = r_press[I_PAUSE];
  assign w_clr_press   = r_press[I_CLEAR];
  assign w_adj         = r_sync2[I_ADJ];

  // Next state: clear beats the adjust level, which beats pause
  always_comb begin
    w_state_nxt = r_state;
    if (w_clr_press) begin
      w_state_nxt = w_adj ? ST_ADJUST : ST_STOPPED;
    end else if (w_adj) begin
      w_state_nxt = ST_ADJUST;
    end else begin
      case (r_state)
        ST_STOPPED: if (w_pause_press) w_state_nxt = ST_RUNNING;
        ST_RUNNING: if (w_pause_press) w_state_nxt = ST_PAUSED;
        ST_PAUSED:  if (w_pause_press) w_state_nxt = ST_RUNNING;
        ST_ADJUST:  w_state_nxt = ST_PAUSED;
        default:    w_state_nxt = ST_STOPPED;
      endcase
    end
  end

  // Prescaler control; PAUSED neither counts nor clears, keeping the fraction
  assign w_adj_edge    = (r_state == ST_ADJUST) != (w_state_nxt == ST_ADJUST);
  assign w_presc_zero  = w_clr_press || w_adj_edge || (w_state_nxt == ST_STOPPED);
  assign w_presc_run   = (r_state == ST_RUNNING) || (r_state == ST_ADJUST);
  assign w_presc_limit = (r_state == ST_ADJUST) ? PW'(TICK_2HZ_DIV - 1)
                                                : PW'(TICK_1HZ_DIV - 1);

  // State register with registered outputs, prescaler and blink generator
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_STOPPED;
      r_presc     <= '0;
      r_blink_cnt <= '0;
      count_tick  <= 1'b0;
      count_clear <= 1'b0;
      running     <= 1'b0;
      adjust      <= 1'b0;
      blink_on    <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      running     <= (w_state_nxt == ST_RUNNING);
      adjust      <= (w_state_nxt == ST_ADJUST);
      count_clear <= w_clr_press;
      count_tick  <= 1'b0;

      if (w_presc_zero) begin
        r_presc <= '0;
      end else if (w_presc_run) begin
        if (r_presc == w_presc_limit) begin
          r_presc    <= '0;
          count_tick <= 1'b1;
        end else begin
          r_presc <= r_presc + PW'(1);
        end
      end

      // Blink restarts visible on every ADJUST entry
      if ((w_state_nxt != ST_ADJUST) || w_adj_edge) begin
        r_blink_cnt <= '0;
        blink_on    <= 1'b1;
      end else if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
        r_blink_cnt <= '0;
        blink_on    <= ~blink_on;
      end else begin
        r_blink_cnt <= r_blink_cnt + BW'(1);
      end
    end
  end

  assign state  = r_state;
  assign select = r_sync2[I_SEL];

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with small parameters. Tick and clear
// pulses are predicted into queues when stimulus is applied and checked off
// as the DUT emits them; state and gate outputs are checked at fixed cycles.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       btn_pause;
  logic       btn_clear;
  logic       sw_adj;
  logic       sw_sel;
  logic       count_tick;
  logic       count_clear;
  logic       running;
  logic       adjust;
  logic       select;
  logic       blink_on;
  logic [1:0] state;

  int          cyc = 0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int          exp_tick_q[$];
  int          exp_clr_q[$];

  stopwatch_ctrl #(
    .TICK_1HZ_DIV(10),
    .TICK_2HZ_DIV(5),
    .DB_CYCLES   (4),
    .BLINK_DIV   (3)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .btn_pause  (btn_pause),
    .btn_clear  (btn_clear),
    .sw_adj     (sw_adj),
    .sw_sel     (sw_sel),
    .count_tick (count_tick),
    .count_clear(count_clear),
    .running    (running),
    .adjust     (adjust),
    .select     (select),
    .blink_on   (blink_on),
    .state      (state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"},  32'(state),       32'd0);
    check({tag, "_run"},    32'(running),     32'd0);
    check({tag, "_adj"},    32'(adjust),      32'd0);
    check({tag, "_tick"},   32'(count_tick),  32'd0);
    check({tag, "_clr"},    32'(count_clear), 32'd0);
    check({tag, "_sel"},    32'(select),      32'd0);
    check({tag, "_blink"},  32'(blink_on),    32'd1);
  endtask

  // Scoreboard: every emitted pulse must match the next predicted cycle
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (count_tick === 1'b1 && count_clear === 1'b1)
        check("tick_clear_exclusive", 32'd1, 32'd0);
      if (count_tick === 1'b1) begin
        if (exp_tick_q.size() != 0) check("tick_cycle", 32'(cyc), 32'(exp_tick_q.pop_front()));
        else                        check("unexpected_tick", 32'(cyc), 32'hFFFF_FFFF);
      end
      if (count_clear === 1'b1) begin
        if (exp_clr_q.size() != 0) check("clear_cycle", 32'(cyc), 32'(exp_clr_q.pop_front()));
        else                       check("unexpected_clear", 32'(cyc), 32'hFFFF_FFFF);
      end
    end
  end

  initial begin
    int d1, r1, q, a, b, c, a2, e, f;
    reset_n   = 1'b0;
    btn_pause = 1'b0;
    btn_clear = 1'b0;
    sw_adj    = 1'b0;
    sw_sel    = 1'b0;

    // Reset state
    wait_to(2);
    check_reset_vals("rst");
    wait_to(3);
    reset_n = 1'b1;

    // Glitches of 2 and 3 cycles are shorter than the debounce window
    wait_to(5);  btn_pause = 1'b1;
    wait_to(7);  btn_pause = 1'b0;
    wait_to(10); btn_pause = 1'b1;
    wait_to(13); btn_pause = 1'b0;
    wait_to(25);
    check("glitch_state", 32'(state), 32'd0);
    check("glitch_run",   32'(running), 32'd0);

    // Held pause: 2 sync + 4 debounce + 1 state cycle until running
    d1 = 30;
    r1 = d1 + 7;
    exp_tick_q.push_back(r1 + 10);
    exp_tick_q.push_back(r1 + 20);
    exp_tick_q.push_back(r1 + 30);
    wait_to(d1);
    btn_pause = 1'b1;
    while (running !== 1'b1 && cyc < d1 + 40) @(negedge clk);
    check("s1_run_rise_cycle", 32'(cyc), 32'(r1));
    check("s1_state", 32'(state), 32'd1);
    wait_to(d1 + 20); btn_pause = 1'b0;
    wait_to(d1 + 28);
    check("s1_single_transition", 32'(state), 32'd1);

    // Pause 6 cycles after the tick at r1+30, resume: 4 cycles remain
    wait_to(r1 + 29); btn_pause = 1'b1;
    wait_to(r1 + 35); btn_pause = 1'b0;
    check("s3_pre_pause", 32'(state), 32'd1);
    wait_to(r1 + 36);
    check("s3_paused", 32'(state), 32'd2);
    check("s3_paused_run", 32'(running), 32'd0);
    q = r1 + 52;
    exp_tick_q.push_back(q + 4);
    exp_tick_q.push_back(q + 14);
    exp_tick_q.push_back(q + 24);
    wait_to(r1 + 45); btn_pause = 1'b1;   // exactly DB_CYCLES long
    wait_to(r1 + 49); btn_pause = 1'b0;
    wait_to(q - 1);
    check("s3_still_paused", 32'(state), 32'd2);
    wait_to(q);
    check("s3_resumed", 32'(running), 32'd1);

    // Adjust from RUNNING: 3-cycle switch latency, 5-cycle ticks, blink/3
    a = q + 29;
    exp_tick_q.push_back(a + 5);
    exp_tick_q.push_back(a + 10);
    exp_tick_q.push_back(a + 15);
    wait_to(q + 26); sw_adj = 1'b1;
    wait_to(q + 27); sw_sel = 1'b1;
    wait_to(q + 28);
    check("s4_pre_adj", 32'(state), 32'd1);
    check("sel_1cyc", 32'(select), 32'd0);
    wait_to(a);
    check("s4_state", 32'(state), 32'd3);
    check("s4_adjust", 32'(adjust), 32'd1);
    check("s4_running", 32'(running), 32'd0);
    check("s4_blink_entry", 32'(blink_on), 32'd1);
    check("sel_2cyc", 32'(select), 32'd1);
    wait_to(a + 2); check("s4_blink_a2", 32'(blink_on), 32'd1);
    wait_to(a + 3); check("s4_blink_a3", 32'(blink_on), 32'd0);
    wait_to(a + 5); check("s4_blink_a5", 32'(blink_on), 32'd0);
    wait_to(a + 6); check("s4_blink_a6", 32'(blink_on), 32'd1);
    wait_to(a + 14); sw_adj = 1'b0;
    wait_to(a + 16); check("s4_blink_pre_exit", 32'(blink_on), 32'd0);
    wait_to(a + 17);
    check("s4_exit_state", 32'(state), 32'd2);
    check("s4_exit_blink", 32'(blink_on), 32'd1);
    check("s4_exit_adjust", 32'(adjust), 32'd0);

    // Clear while RUNNING, landing on the cycle a tick would fire
    b = a + 30;
    c = b + 10;
    exp_clr_q.push_back(c);
    wait_to(b - 7); btn_pause = 1'b1;
    wait_to(b - 1); btn_pause = 1'b0;
    wait_to(b);     check("s5_running", 32'(state), 32'd1);
    wait_to(c - 7); btn_clear = 1'b1;
    wait_to(c - 1); btn_clear = 1'b0;
    check("s5_pre_clear", 32'(state), 32'd1);
    wait_to(c);
    check("s5_clear_state", 32'(state), 32'd0);
    check("s5_clear_pulse", 32'(count_clear), 32'd1);
    check("s5_no_tick", 32'(count_tick), 32'd0);

    // Clear inside ADJUST keeps ADJUST and restarts the prescaler
    a2 = c + 8;
    exp_tick_q.push_back(a2 + 5);
    exp_clr_q.push_back(a2 + 7);
    exp_tick_q.push_back(a2 + 12);
    exp_tick_q.push_back(a2 + 17);
    wait_to(c + 5); sw_adj = 1'b1;
    wait_to(a2);
    check("s5_adj_state", 32'(state), 32'd3);
    btn_clear = 1'b1;
    wait_to(a2 + 6); btn_clear = 1'b0;
    wait_to(a2 + 7);
    check("s5_adj_clear_state", 32'(state), 32'd3);
    check("s5_adj_clear_pulse", 32'(count_clear), 32'd1);
    wait_to(a2 + 18); sw_adj = 1'b0;
    wait_to(a2 + 21);
    check("s5_adj_exit", 32'(state), 32'd2);

    // Simultaneous clear and pause from PAUSED: clear wins
    e = a2 + 32;
    exp_clr_q.push_back(e);
    wait_to(e - 7); btn_pause = 1'b1; btn_clear = 1'b1;
    wait_to(e - 1); btn_pause = 1'b0; btn_clear = 1'b0;
    wait_to(e);
    check("s6_both_state", 32'(state), 32'd0);
    check("s6_both_clear", 32'(count_clear), 32'd1);
    check("s6_both_run", 32'(running), 32'd0);
    wait_to(e + 3);
    check("s6_stays_stopped", 32'(state), 32'd0);

    // Reset mid-count while ADJUST has blink_on low and select high
    f = e + 15;
    wait_to(f - 7); btn_pause = 1'b1;
    wait_to(f - 1); btn_pause = 1'b0;
    wait_to(f);     check("s6_run", 32'(state), 32'd1);
    wait_to(f + 2); sw_adj = 1'b1;
    wait_to(f + 9);
    check("s6_pre_rst_state", 32'(state), 32'd3);
    check("s6_pre_rst_blink", 32'(blink_on), 32'd0);
    reset_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    sw_adj = 1'b0;
    sw_sel = 1'b0;
    wait_to(f + 12);
    check_reset_vals("midrst_hold");
    reset_n = 1'b1;
    wait_to(f + 30);
    check("post_rst_state", 32'(state), 32'd0);

    check("tick_queue_drained", 32'(exp_tick_q.size()), 32'd0);
    check("clear_queue_drained", 32'(exp_clr_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
